// File: rtl/dmem_responder_pkg.sv
// Shared types and sizes for the data-memory responder.
package dmem_responder_pkg;

   localparam int DM_ADDR_W       = 12;
   localparam int DM_DATA_W       = 32;
   localparam int DMEM_DEPTH      = 4096;
   localparam int DMEM_WBUF_DEPTH = 2;

   // One posted write waiting to reach the array.
   typedef struct packed {
      logic [DM_ADDR_W-1:0] addr;
      logic [DM_DATA_W-1:0] data;
   } wbuf_entry_t;

   typedef enum logic {DM_INIT, DM_RUN} dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// MA-stage dmem request/response bundle.
interface dmem_responder_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   logic [AW-1:0] dmem_waddr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_wen;
   logic [AW-1:0] dmem_raddr;
   logic          dmem_ren;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_rvalid;
   logic          dmem_stall;
   logic          init_busy;
   logic          dmem_err;

   modport master (
      output dmem_waddr, dmem_wdata, dmem_wen, dmem_raddr, dmem_ren,
      input  dmem_rdata, dmem_rvalid, dmem_stall, init_busy, dmem_err
   );

   modport slave (
      input  dmem_waddr, dmem_wdata, dmem_wen, dmem_raddr, dmem_ren,
      output dmem_rdata, dmem_rvalid, dmem_stall, init_busy, dmem_err
   );
endinterface

// File: rtl/dmem_wbuf.sv
// Posted-write FIFO with a youngest-hit address search for read forwarding.
module dmem_wbuf
   import dmem_responder_pkg::*;
#(
   parameter int WBUF_DEPTH = DMEM_WBUF_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  wbuf_entry_t          push_entry,
   input  logic                 pop,
   output wbuf_entry_t          head_entry,
   output logic                 full,
   output logic                 empty,
   input  logic [DM_ADDR_W-1:0] lkp_addr,
   output logic                 lkp_hit,
   output logic [DM_DATA_W-1:0] lkp_data
);
   localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
   localparam int CW = $clog2(WBUF_DEPTH + 1);

   wbuf_entry_t   ent [WBUF_DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Pointers and occupancy; push and pop may happen in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= ptr_inc(tail);
         if (pop)  head <= ptr_inc(head);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Entry storage needs no reset: occupancy decides what is live.
   always_ff @(posedge clk) begin
      if (push) ent[tail] <= push_entry;
   end

   assign head_entry = ent[head];
   assign full       = (count == CW'(WBUF_DEPTH));
   assign empty      = (count == '0);

   // Walk oldest to youngest so the last match (the youngest write) wins.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      lkp_hit  = 1'b0;
      lkp_data = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         sum = {1'b0, head} + (PW+1)'(i);
         if (sum >= (PW+1)'(WBUF_DEPTH)) sum = sum - (PW+1)'(WBUF_DEPTH);
         idx = sum[PW-1:0];
         if ((CW'(i) < count) && (ent[idx].addr == lkp_addr)) begin
            lkp_hit  = 1'b1;
            lkp_data = ent[idx].data;
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-ported word array, posted write buffer,
// post-reset array clear and read/drain arbitration.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   // Buffer entries are typed at the package widths; keep these equal to them.
   parameter int MEM_ADDR_WIDTH = DM_ADDR_W,
   parameter int MEM_DATA_WIDTH = DM_DATA_W,
   parameter int DEPTH          = DMEM_DEPTH,
   parameter int WBUF_DEPTH     = DMEM_WBUF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [MEM_ADDR_WIDTH:0] DEPTH_W = (MEM_ADDR_WIDTH+1)'(DEPTH);

   dmem_state_e               state, state_nxt;
   logic [IW-1:0]             cnt;
   logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

   logic                      mem_we;
   logic [IW-1:0]             mem_addr;
   logic [MEM_DATA_WIDTH-1:0] mem_wdata;
   logic                      stall, busy, pop, push, rd_acc, rd_oor, wr_oor;
   logic                      wb_full, wb_empty, lkp_hit;
   logic [MEM_DATA_WIDTH-1:0] lkp_data;
   wbuf_entry_t               head_entry, push_entry;
   logic [MEM_DATA_WIDTH-1:0] rdata_q;
   logic                      rvalid_q, err_q;

   // Full-width compare, so high address bits never alias into the array.
   assign rd_oor = ({1'b0, bus.dmem_raddr} >= DEPTH_W);
   assign wr_oor = ({1'b0, bus.dmem_waddr} >= DEPTH_W);

   assign push       = (state == DM_RUN) && bus.dmem_wen && !wr_oor;
   assign rd_acc     = (state == DM_RUN) && bus.dmem_ren && !stall;
   assign push_entry = '{addr: bus.dmem_waddr, data: bus.dmem_wdata};

   dmem_wbuf #(.WBUF_DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .full       (wb_full),
      .empty      (wb_empty),
      .lkp_addr   (bus.dmem_raddr),
      .lkp_hit    (lkp_hit),
      .lkp_data   (lkp_data)
   );

   // State register and clear counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DM_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == DM_INIT) cnt <= cnt + 1'b1;
      end
   end

   // Next state and array-port arbitration: full drain > read > idle drain.
   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_addr  = cnt;
      mem_wdata = '0;
      pop       = 1'b0;
      stall     = 1'b0;
      busy      = 1'b0;
      case (state)
         DM_INIT: begin
            busy   = 1'b1;
            stall  = 1'b1;
            mem_we = 1'b1;
            if (cnt == IW'(DEPTH - 1)) state_nxt = DM_RUN;
         end
         DM_RUN: begin
            if (wb_full || (!bus.dmem_ren && !wb_empty)) begin
               pop       = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = head_entry.addr[IW-1:0];
               mem_wdata = head_entry.data;
               stall     = bus.dmem_ren && wb_full;
            end
         end
         default: state_nxt = DM_INIT;
      endcase
   end

   // Array write port; at most one access per cycle by construction above.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // Read response and sticky range error. Buffer lookup sees pre-push state.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= rd_acc;
         if (rd_acc) begin
            if (rd_oor)       rdata_q <= '0;
            else if (lkp_hit) rdata_q <= lkp_data;
            else              rdata_q <= mem[bus.dmem_raddr[IW-1:0]];
         end
         if ((rd_acc && rd_oor) || ((state == DM_RUN) && bus.dmem_wen && wr_oor))
            err_q <= 1'b1;
      end
   end

   assign bus.dmem_rdata  = rdata_q;
   assign bus.dmem_rvalid = rvalid_q;
   assign bus.dmem_err    = err_q;
   assign bus.dmem_stall  = stall;
   assign bus.init_busy   = busy;

endmodule
